// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, the halt opcode and the fetch FSM states.
// S_HALT exists only when IFETCH_HALT_EN is defined.
package cpu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned FUNC_W  = 3;

    localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
`ifdef IFETCH_HALT_EN
        , S_HALT
`endif
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

    function automatic logic [FUNC_W-1:0] func_of(input logic [INSTR_W-1:0] instr);
        return instr[FUNC_W-1:0];
    endfunction

endpackage

// File: rtl/ifetch_pc.sv
// Program counter register with redirect / increment / hold selection.
// Redirect wins over increment; increment wraps modulo 2^PC_W.
module ifetch_pc #(
    parameter int unsigned      PC_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_next;

    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_addr;
        end else if (inc) begin
            pc_next = pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: request/hold FSM feeding a one-entry decode register.
// Optional halt support is enabled by defining IFETCH_HALT_EN.
module ifetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned      PC_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(16'h0000)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [OPC_W-1:0]   id_opcode,
    output logic [FUNC_W-1:0]  id_func,
    output logic               halted
);

    fetch_state_t    state, state_next;
    logic            bubble;
    logic [PC_W-1:0] pc;
    logic            fetch_done;

    // The cycle after a redirect sits in S_REQ with the request masked,
    // giving exactly one dead cycle before fetching at the new target.
    assign imem_req   = (state == S_REQ) && !bubble;
    assign imem_addr  = pc;
    assign fetch_done = imem_req && imem_ack && !br_taken;

    assign id_opcode = opcode_of(id_instr);
    assign id_func   = func_of(id_instr);

`ifdef IFETCH_HALT_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    ifetch_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (fetch_done),
        .load      (br_taken),
        .load_addr (br_target),
        .pc        (pc)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (imem_ack && !bubble) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (id_ready) begin
`ifdef IFETCH_HALT_EN
                    state_next = (id_opcode == OPC_HALT) ? S_HALT : S_REQ;
`else
                    state_next = S_REQ;
`endif
                end
            end
`ifdef IFETCH_HALT_EN
            S_HALT: state_next = S_HALT;
`endif
            default: state_next = S_IDLE;
        endcase
        if (br_taken) begin
            state_next = S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            bubble <= 1'b0;
        end else begin
            state  <= state_next;
            bubble <= br_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (br_taken) begin
            id_valid <= 1'b0;
        end else if (fetch_done) begin
            id_instr <= imem_rdata;
            id_pc    <= pc;
            id_valid <= 1'b1;
        end else if ((state == S_HOLD) && id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage (default instance plus a RESET_PC=16'hFFFF wrap instance).
// Halt-path steps are compiled in when IFETCH_HALT_EN is defined.
module tb_ifetch_stage;

    logic        clk;
    logic        rst_n;
    logic        ack_auto, ack_force;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        br_taken, id_ready;
    logic [15:0] br_target;
    logic        id_valid, halted;
    logic [15:0] id_instr, id_pc;
    logic [3:0]  id_opcode;
    logic [2:0]  id_func;

    logic        w_req, w_valid, w_halted;
    logic [15:0] w_addr, w_instr, w_pc;
    logic [3:0]  w_opcode;
    logic [2:0]  w_func;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned fails = 0;

    assign imem_ack = ack_force | (ack_auto & imem_req);

    ifetch_stage u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_opcode  (id_opcode),
        .id_func    (id_func),
        .halted     (halted)
    );

    ifetch_stage #(
        .PC_W     (16),
        .RESET_PC (16'hFFFF)
    ) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_ack   (w_req),
        .imem_rdata (16'h7000),
        .br_taken   (1'b0),
        .br_target  (16'h0000),
        .id_ready   (1'b1),
        .id_valid   (w_valid),
        .id_instr   (w_instr),
        .id_pc      (w_pc),
        .id_opcode  (w_opcode),
        .id_func    (w_func),
        .halted     (w_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ack_auto = 1'b0; ack_force = 1'b0;
        imem_rdata = 16'h0000; br_taken = 1'b0; br_target = 16'h0000; id_ready = 1'b0;

        #3;
        chk("rst_req",    {31'b0, imem_req}, 32'h0);
        chk("rst_valid",  {31'b0, id_valid}, 32'h0);
        chk("rst_instr",  {16'b0, id_instr}, 32'h0);
        chk("rst_pc",     {16'b0, id_pc},    32'h0);
        chk("rst_halted", {31'b0, halted},   32'h0);
        chk("rst_w_req",  {31'b0, w_req},    32'h0);

        tick(); tick();
        rst_n = 1'b1;
        chk("idle_req", {31'b0, imem_req}, 32'h0);

        // First fetch: ack in the same cycle as the request.
        tick();
        chk("f0_req",    {31'b0, imem_req}, 32'h1);
        chk("f0_addr",   {16'b0, imem_addr}, 32'h0);
        chk("w0_addr",   {16'b0, w_addr},   32'hFFFF);
        ack_auto = 1'b1; imem_rdata = 16'h1234; id_ready = 1'b1;
        tick();
        chk("f0_valid",  {31'b0, id_valid}, 32'h1);
        chk("f0_id_pc",  {16'b0, id_pc},    32'h0);
        chk("f0_instr",  {16'b0, id_instr}, 32'h1234);
        chk("f0_opcode", {28'b0, id_opcode}, 32'h1);
        chk("f0_func",   {29'b0, id_func},  32'h4);
        chk("f0_hold_req", {31'b0, imem_req}, 32'h0);
        chk("w0_valid",  {31'b0, w_valid},  32'h1);
        chk("w0_id_pc",  {16'b0, w_pc},     32'hFFFF);
        tick();
        chk("f1_req",    {31'b0, imem_req}, 32'h1);
        chk("f1_addr",   {16'b0, imem_addr}, 32'h1);
        chk("f1_valid",  {31'b0, id_valid}, 32'h0);
        chk("w1_addr",   {16'b0, w_addr},   32'h0);

        // Decode stalls for five cycles while holding the instruction.
        imem_rdata = 16'hABCD; id_ready = 1'b0;
        tick();
        chk("w1_id_pc",  {16'b0, w_pc},     32'h0);
        chk("st_valid0", {31'b0, id_valid}, 32'h1);
        imem_rdata = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            chk("st_req",   {31'b0, imem_req}, 32'h0);
            chk("st_instr", {16'b0, id_instr}, 32'hABCD);
            chk("st_id_pc", {16'b0, id_pc},    32'h1);
            chk("st_valid", {31'b0, id_valid}, 32'h1);
            tick();
        end
        id_ready = 1'b1; ack_auto = 1'b0;
        tick();
        chk("st_next_req",  {31'b0, imem_req}, 32'h1);
        chk("st_next_addr", {16'b0, imem_addr}, 32'h2);
        chk("st_next_valid", {31'b0, id_valid}, 32'h0);

        // Request held stable without ack; id_ready with nothing valid is inert.
        tick(); tick();
        chk("wait_req",   {31'b0, imem_req}, 32'h1);
        chk("wait_addr",  {16'b0, imem_addr}, 32'h2);
        chk("wait_valid", {31'b0, id_valid}, 32'h0);

        // Redirect coinciding with ack: data dropped, one dead cycle.
        ack_auto = 1'b1; imem_rdata = 16'h5555; br_taken = 1'b1; br_target = 16'h0040;
        #1;
        chk("br_ack_seen", {31'b0, imem_ack}, 32'h1);
        tick();
        br_taken = 1'b0; br_target = 16'h0000; ack_auto = 1'b0;
        chk("br_valid",  {31'b0, id_valid}, 32'h0);
        chk("br_bubble", {31'b0, imem_req}, 32'h0);
        chk("br_instr_kept", {16'b0, id_instr}, 32'hABCD);
        tick();
        chk("br_req",    {31'b0, imem_req}, 32'h1);
        chk("br_addr",   {16'b0, imem_addr}, 32'h0040);

        ack_auto = 1'b1; imem_rdata = 16'hF00F; id_ready = 1'b0;
        tick();
        chk("hf_valid",  {31'b0, id_valid}, 32'h1);
        chk("hf_id_pc",  {16'b0, id_pc},    32'h0040);
        chk("hf_opcode", {28'b0, id_opcode}, 32'hF);
        chk("hf_func",   {29'b0, id_func},  32'h7);
        id_ready = 1'b1; ack_auto = 1'b0;
        tick();
`ifdef IFETCH_HALT_EN
        chk("halt_flag",  {31'b0, halted},   32'h1);
        chk("halt_req",   {31'b0, imem_req}, 32'h0);
        chk("halt_valid", {31'b0, id_valid}, 32'h0);
        tick(); tick();
        chk("halt_stay",  {31'b0, halted},   32'h1);
        chk("halt_req2",  {31'b0, imem_req}, 32'h0);
        br_taken = 1'b1; br_target = 16'h0010;
        tick();
        br_taken = 1'b0;
        chk("unhalt_flag", {31'b0, halted},   32'h0);
        chk("unhalt_bub",  {31'b0, imem_req}, 32'h0);
        tick();
        chk("unhalt_req",  {31'b0, imem_req}, 32'h1);
        chk("unhalt_addr", {16'b0, imem_addr}, 32'h0010);
`else
        chk("nohalt_flag", {31'b0, halted},   32'h0);
        chk("nohalt_req",  {31'b0, imem_req}, 32'h1);
        chk("nohalt_addr", {16'b0, imem_addr}, 32'h0041);
`endif

        // Asynchronous reset in the middle of a pending request.
        ack_force = 1'b1; imem_rdata = 16'h9999;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",    {31'b0, imem_req}, 32'h0);
        chk("ar_valid",  {31'b0, id_valid}, 32'h0);
        chk("ar_instr",  {16'b0, id_instr}, 32'h0);
        chk("ar_id_pc",  {16'b0, id_pc},    32'h0);
        chk("ar_halted", {31'b0, halted},   32'h0);
        chk("ar_addr",   {16'b0, imem_addr}, 32'h0);
        tick();
        ack_force = 1'b0;
        #2 ack_force = 1'b1;
        tick();
        chk("ar_hold_valid", {31'b0, id_valid}, 32'h0);
        chk("ar_hold_req",   {31'b0, imem_req}, 32'h0);
        ack_force = 1'b0;
        rst_n = 1'b1; ack_auto = 1'b1; imem_rdata = 16'h2222; id_ready = 1'b1;
        chk("ar_idle_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("ar_f_req",  {31'b0, imem_req}, 32'h1);
        chk("ar_f_addr", {16'b0, imem_addr}, 32'h0);
        tick();
        chk("ar_f_valid", {31'b0, id_valid}, 32'h1);
        chk("ar_f_id_pc", {16'b0, id_pc},    32'h0);
        chk("ar_f_instr", {16'b0, id_instr}, 32'h2222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_W, default 16, SHALL be the PC and instruction-memory address width.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: SHALL be the asynchronous, active-low reset.
REQ-005 Port imem_req, output, 1: SHALL be the instruction-memory read request.
REQ-006 Port imem_addr, output, PC_W: SHALL be the word address being read.
REQ-007 Port imem_ack, input, 1: SHALL mean the read completed this cycle; valid only while imem_req=1.
REQ-008 Port imem_rdata, input, 16: SHALL be the instruction word, sampled when imem_ack=1.
REQ-009 Port br_taken, input, 1: SHALL be the single-cycle redirect pulse from the execute stage.
REQ-010 Port br_target, input, PC_W: SHALL be the redirect address, sampled when br_taken=1.
REQ-011 Port id_ready, input, 1: SHALL mean the decode stage accepts the held instruction this cycle.
REQ-012 Port id_valid, output, 1: SHALL mean the id_* outputs hold a valid instruction.
REQ-013 Ports id_instr [16], id_pc [PC_W], id_opcode [4] = id_instr[15:12], id_func [3] = id_instr[2:0], outputs: SHALL carry the held instruction, its address and the decoder fields.
REQ-014 Port halted, output, 1: SHALL flag the halt state (constant 0 without IFETCH_HALT_EN).

Function
REQ-015 FSM states SHALL be S_IDLE, S_REQ, S_HOLD and, with the macro only, S_HALT.
REQ-016 S_IDLE SHALL last exactly one cycle after reset release, then go to S_REQ.
REQ-017 In S_REQ, imem_req=1 and imem_addr=pc SHALL hold, stable, until imem_ack.
REQ-018 On imem_ack in S_REQ: id_instr<=imem_rdata, id_pc<=pc, pc<=pc+1, id_valid<=1, and the FSM SHALL go to S_HOLD; ack-to-valid latency is 1 cycle.
REQ-019 In S_HOLD with id_ready=1: id_valid<=0 and the FSM SHALL go to S_REQ; with id_ready=0, all id_* outputs SHALL hold unchanged.
REQ-020 pc+1 SHALL wrap modulo 2^PC_W (16'hFFFF -> 16'h0000).
REQ-021 br_taken SHALL have priority in every state: pc<=br_target, id_valid<=0, next state S_REQ, and any imem_ack in the same cycle is discarded.
REQ-022 After a redirect, imem_req SHALL be 0 for exactly one cycle before the request to br_target.
REQ-023 id_ready while id_valid=0 SHALL have no effect.

Reset
REQ-024 On rst_n=0, asynchronously: pc=RESET_PC, state=S_IDLE, id_valid=0, id_instr=0, id_pc=0, imem_req=0, halted=0.
REQ-025 Reset during S_REQ SHALL drop imem_req immediately and ignore any imem_ack while rst_n=0.

Configuration
REQ-026 With IFETCH_HALT_EN defined: an instruction with opcode 4'b1111 SHALL enter S_HALT when accepted by id_ready; in S_HALT, halted=1, imem_req=0 and id_valid=0, and the FSM SHALL leave S_HALT only on br_taken or reset.
REQ-027 Without IFETCH_HALT_EN: opcode 4'b1111 SHALL flow like any other instruction, S_HALT SHALL not exist, and halted SHALL be tied to 0.

Structure
REQ-028 Shared package cpu_pkg SHALL hold INSTR_W=16, OPC_W=4, FUNC_W=3, OPC_HALT=4'b1111 and the fetch-state enum.
REQ-029 The PC register and next-PC mux (increment/redirect/hold) SHALL be the sub-module ifetch_pc; the FSM and the id_* register SHALL stay in ifetch_stage.

Verification
REQ-030 Reset release, imem_ack same cycle as req, rdata=16'h1234, id_ready=1 -> imem_addr=0, then id_valid with id_pc=0, id_opcode=4'h1, id_func=3'h4; next request at imem_addr=1.
REQ-031 id_ready=0 for 5 cycles after id_valid -> id_instr/id_pc stable, imem_req=0 throughout; id_ready=1 -> request at pc+1.
REQ-032 br_taken with br_target=16'h0040 in the same cycle as imem_ack -> data dropped, id_valid=0, one idle cycle, then imem_addr=16'h0040.
REQ-033 RESET_PC=16'hFFFF, two fetches -> id_pc=16'hFFFF, then id_pc=16'h0000.
REQ-034 IFETCH_HALT_EN defined, rdata=16'hF000 accepted -> halted=1, no imem_req; br_taken to 16'h0010 -> halted=0, fetch at 16'h0010.
REQ-035 rst_n asserted mid-S_REQ with imem_ack pulsing -> all outputs at reset values immediately; after release, first fetch at RESET_PC.
